// File: rtl/cpu_pkg.sv
// Shared ALU opcodes, serial ALU state encoding and default datapath width.
// Definitions only; no latency and no backpressure.
package cpu_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_SRL  = 3'b110;
    localparam logic [2:0] ALU_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2
    } alu_state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/serial_add_sub.sv
// One-bit serial adder/subtractor: the sum is combinational and the carry is registered.
// No backpressure; the carry advances only on cycles where en is high.
module serial_add_sub (
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic en,
    input  logic sub,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    logic c;
    logic bx;

    // Subtraction is a + ~b + 1: invert b and preload the carry with 1.
    assign bx   = b ^ sub;
    assign sum  = a ^ bx ^ c;
    assign cout = c;

    always_ff @(posedge clk) begin
        if (rst) begin
            c <= 1'b0;
        end else if (init) begin
            c <= sub;
        end else if (en) begin
            c <= (a & bx) | (a & c) | (bx & c);
        end
    end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU and accumulator. One operation takes 10 cycles: start, WIDTH shift cycles, then one write cycle.
// No backpressure: a start that arrives while busy is dropped.
module alu_serial
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic             imm_sel,
    input  logic [WIDTH-1:0] imm,
    input  logic             wr_en,
    input  logic             rs1_bit,
    input  logic             rs2_bit,
    output logic             reg_shift_en,
    output logic             reg_store_en,
    output logic [WIDTH-1:0] acc_out,
    output logic             busy,
    output logic             done,
    output logic             carry_flag,
    output logic             zero_flag
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    alu_state_t       state;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic             imm_sel_q;
    logic [WIDTH-1:0] imm_q;
    logic             wr_q;
    logic [WIDTH-1:0] acc;

    logic accept;
    logic b_bit;
    logic r_bit;
    logic add_sub;
    logic add_en;
    logic sum;
    logic cout;

    assign accept  = (state == ST_IDLE) && start;
    assign b_bit   = imm_sel_q ? imm_q[cnt] : rs2_bit;
    // The carry is preloaded on the accept edge, before op_q holds the new opcode.
    assign add_sub = accept ? (alu_op == ALU_SUB) : (op_q == ALU_SUB);
    assign add_en  = (state == ST_SHIFT) && is_arith(op_q);
    assign acc_out = acc;

    serial_add_sub u_add_sub (
        .clk  (clk),
        .rst  (rst),
        .init (accept),
        .en   (add_en),
        .sub  (add_sub),
        .a    (rs1_bit),
        .b    (b_bit),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        r_bit = rs1_bit;
        case (op_q)
            ALU_ADD, ALU_SUB: r_bit = sum;
            ALU_AND:          r_bit = rs1_bit & b_bit;
            ALU_OR:           r_bit = rs1_bit | b_bit;
            ALU_XOR:          r_bit = rs1_bit ^ b_bit;
            default:          r_bit = rs1_bit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            op_q         <= ALU_ADD;
            imm_sel_q    <= 1'b0;
            imm_q        <= '0;
            wr_q         <= 1'b0;
            acc          <= '0;
            reg_shift_en <= 1'b0;
            reg_store_en <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            carry_flag   <= 1'b0;
            zero_flag    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q         <= alu_op;
                        imm_sel_q    <= imm_sel;
                        imm_q        <= imm;
                        wr_q         <= wr_en;
                        cnt          <= '0;
                        reg_shift_en <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc <= {r_bit, acc[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        reg_shift_en <= 1'b0;
                        reg_store_en <= wr_q;
                        done         <= 1'b1;
                        state        <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    carry_flag   <= is_arith(op_q) ? cout : 1'b0;
                    zero_flag    <= (acc == '0);
                    reg_store_en <= 1'b0;
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// Randomised self-checking bench for alu_serial against a cycle-count based reference model.
module tb_alu_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] alu_op = 3'd0;
    logic       imm_sel = 1'b0;
    logic [7:0] imm = 8'd0;
    logic       wr_en = 1'b0;
    logic       rs1_bit;
    logic       rs2_bit;
    logic       reg_shift_en;
    logic       reg_store_en;
    logic [7:0] acc_out;
    logic       busy;
    logic       done;
    logic       carry_flag;
    logic       zero_flag;

    int errors = 0;
    int checks = 0;

    alu_serial #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .alu_op       (alu_op),
        .imm_sel      (imm_sel),
        .imm          (imm),
        .wr_en        (wr_en),
        .rs1_bit      (rs1_bit),
        .rs2_bit      (rs2_bit),
        .reg_shift_en (reg_shift_en),
        .reg_store_en (reg_store_en),
        .acc_out      (acc_out),
        .busy         (busy),
        .done         (done),
        .carry_flag   (carry_flag),
        .zero_flag    (zero_flag)
    );

    always #5 clk = ~clk;

    // Register-file stand-in: streams the operand registers LSB-first.
    logic [7:0] rs1_val = 8'd0;
    logic [7:0] rs2_val = 8'd0;
    logic [2:0] bidx = 3'd0;
    always @(posedge clk) begin
        if (rst) bidx <= 3'd0;
        else if (reg_shift_en) bidx <= bidx + 3'd1;
    end
    assign rs1_bit = rs1_val[bidx];
    assign rs2_bit = rs2_val[bidx];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: m_rem counts cycles left in the current op (9 = first shift cycle, 1 = write cycle).
    int         m_rem = 0;
    bit         m_valid = 0;
    logic       m_wr = 1'b0;
    logic       m_arith = 1'b0;
    logic [7:0] m_res = 8'd0;
    logic       m_carry = 1'b0;
    logic [7:0] m_acc = 8'd0;
    logic       m_cf = 1'b0;
    logic       m_zf = 1'b0;

    always @(posedge clk) begin
        logic [7:0] bv;
        logic [8:0] s;
        m_valid = 1;
        if (rst) begin
            m_rem = 0; m_acc = 8'd0; m_cf = 1'b0; m_zf = 1'b0; m_wr = 1'b0;
        end else if (m_rem == 0) begin
            if (start) begin
                bv = imm_sel ? imm : rs2_val;
                m_carry = 1'b0;
                m_arith = 1'b0;
                case (alu_op)
                    3'd0: begin s = {1'b0, rs1_val} + {1'b0, bv}; m_res = s[7:0]; m_carry = s[8]; m_arith = 1'b1; end
                    3'd1: begin m_res = rs1_val - bv; m_carry = (rs1_val >= bv); m_arith = 1'b1; end
                    3'd2: m_res = rs1_val & bv;
                    3'd3: m_res = rs1_val | bv;
                    3'd4: m_res = rs1_val ^ bv;
                    default: m_res = rs1_val;
                endcase
                m_wr  = wr_en;
                m_acc = m_res;
                m_rem = 9;
            end
        end else begin
            if (m_rem == 1) begin
                m_cf = m_arith ? m_carry : 1'b0;
                m_zf = (m_res == 8'd0);
            end
            m_rem = m_rem - 1;
        end
    end

    int shift_run = 0;
    int store_cnt = 0;
    int done_cnt  = 0;
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", busy, m_rem > 0);
            chk("reg_shift_en", reg_shift_en, m_rem >= 2);
            chk("reg_store_en", reg_store_en, (m_rem == 1) && m_wr);
            chk("done", done, m_rem == 1);
            chk("carry_flag", carry_flag, m_cf);
            chk("zero_flag", zero_flag, m_zf);
            if (m_rem <= 1) chk("acc_out", acc_out, m_acc);
            chk("shift_store_overlap", reg_shift_en & reg_store_en, 1'b0);
            if (m_rem == 0) shift_run = 0;
            if (reg_shift_en) shift_run++;
            if (reg_store_en) store_cnt++;
            if (done) begin
                done_cnt++;
                chk("shift_len", shift_run, 8);
                shift_run = 0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", busy, 1'b0);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic isel, input logic [7:0] im, input logic wr, input bit junk);
        wait_idle();
        rs1_val = a; rs2_val = b;
        alu_op = op; imm_sel = isel; imm = im; wr_en = wr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (junk && $urandom_range(0, 2) == 0) begin
                start   = 1'b1;
                alu_op  = 3'($urandom);
                imm     = 8'($urandom);
                imm_sel = 1'($urandom);
                wr_en   = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic isel, input logic [7:0] im, input logic wr,
                            input logic [7:0] exp_acc, input logic exp_c, input logic exp_z);
        int s0;
        s0 = store_cnt;
        run_op(op, a, b, isel, im, wr, 1'b0);
        chk({nm, "_acc"}, acc_out, exp_acc);
        chk({nm, "_carry"}, carry_flag, exp_c);
        chk({nm, "_zero"}, zero_flag, exp_z);
        chk({nm, "_stores"}, store_cnt - s0, wr ? 1 : 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int dcount;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_acc", acc_out, 8'h00);
        chk("rst_shift", reg_shift_en, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        directed("add",     3'd0, 8'h5A, 8'h27, 1'b0, 8'h00, 1'b1, 8'h81, 1'b0, 1'b0);
        directed("sub_cmp", 3'd1, 8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
        directed("add_imm", 3'd0, 8'hFF, 8'h00, 1'b1, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1);
        directed("and",     3'd2, 8'hF0, 8'h3C, 1'b0, 8'h00, 1'b1, 8'h30, 1'b0, 1'b0);
        directed("or",      3'd3, 8'hF0, 8'h3C, 1'b0, 8'h00, 1'b1, 8'hFC, 1'b0, 1'b0);
        directed("xor",     3'd4, 8'hF0, 8'h3C, 1'b0, 8'h00, 1'b1, 8'hCC, 1'b0, 1'b0);
        directed("pass",    3'd7, 8'hF0, 8'h3C, 1'b0, 8'h00, 1'b1, 8'hF0, 1'b0, 1'b0);
        directed("sub_brw", 3'd1, 8'h03, 8'h05, 1'b0, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0);

        // start held high: accepted every 10 cycles
        wait_idle();
        rs1_val = 8'h03; rs2_val = 8'h04; alu_op = 3'd0; imm_sel = 1'b0; wr_en = 1'b1;
        start = 1'b1;
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        start = 1'b0;
        chk("held_start_dones", dcount, 3);

        // reset in the fourth shift cycle
        wait_idle();
        rs1_val = 8'h77; rs2_val = 8'h11; alu_op = 3'd0; imm_sel = 1'b0; wr_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_shift", reg_shift_en, 1'b0);
        chk("midrst_store", reg_store_en, 1'b0);
        chk("midrst_acc", acc_out, 8'h00);
        chk("midrst_flags", {carry_flag, zero_flag, done}, 3'b000);
        directed("post_rst_add", 3'd0, 8'h01, 8'h01, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            run_op(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                   8'($urandom), 1'($urandom), 1'b1);
        end
        wait_idle();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
